// File: rtl/ecc_core_arbiter_pkg.sv
// Shared encodings for the ECC core arbiter: operand width selects, FSM states
// and the mode-to-width helper used by the operand mask.
package ecc_core_arbiter_pkg;

  localparam int unsigned EccMaxBits = 128;

  typedef enum logic [1:0] {
    Bits16  = 2'd0,
    Bits32  = 2'd1,
    Bits64  = 2'd2,
    Bits128 = 2'd3
  } ecc_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  function automatic int unsigned mode_width(input logic [1:0] mode);
    int unsigned width;
    case (mode)
      Bits16:  width = 16;
      Bits32:  width = 32;
      Bits64:  width = 64;
      default: width = 128;
    endcase
    return width;
  endfunction

endpackage

// File: rtl/ecc_width_mask.sv
// Combinational operand mask: ones below the width selected by i_mode, zeros at
// and above it.
module ecc_width_mask
  import ecc_core_arbiter_pkg::*;
#(
  parameter int unsigned MaxBits = EccMaxBits
) (
  input  logic [1:0]         i_mode,
  output logic [MaxBits-1:0] o_mask
);

  int unsigned w_width;

  always_comb begin
    w_width = mode_width(i_mode);
    for (int unsigned i = 0; i < MaxBits; i++) begin
      o_mask[i] = (i < w_width);
    end
  end

endmodule

// File: rtl/ecc_core_arbiter.sv
// Round-robin arbiter sharing one double-and-add scalar-multiplication core
// between two requesters, with a single-entry response buffer and latency report.
module ecc_core_arbiter
  import ecc_core_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BITS = EccMaxBits,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  // requester 0
  input  logic                r0_req_valid,
  output logic                r0_req_ready,
  input  logic [MAX_BITS-1:0] r0_px,
  input  logic [MAX_BITS-1:0] r0_py,
  input  logic [MAX_BITS-1:0] r0_m,
  // requester 1
  input  logic                r1_req_valid,
  output logic                r1_req_ready,
  input  logic [MAX_BITS-1:0] r1_px,
  input  logic [MAX_BITS-1:0] r1_py,
  input  logic [MAX_BITS-1:0] r1_m,
  // configuration, sampled at grant
  input  logic [MAX_BITS-1:0] cfg_a,
  input  logic [MAX_BITS-1:0] cfg_prime,
  input  logic [1:0]          cfg_mode,
  // responses
  output logic                r0_rsp_valid,
  output logic                r1_rsp_valid,
  input  logic                r0_rsp_ready,
  input  logic                r1_rsp_ready,
  output logic [MAX_BITS-1:0] rsp_x,
  output logic [MAX_BITS-1:0] rsp_y,
  output logic                rsp_owner,
  // core interface
  output logic                core_valid,
  output logic [MAX_BITS-1:0] core_a,
  output logic [MAX_BITS-1:0] core_prime,
  output logic [MAX_BITS-1:0] core_pointx,
  output logic [MAX_BITS-1:0] core_pointy,
  output logic [MAX_BITS-1:0] core_mul,
  output logic [1:0]          core_mode,
  input  logic [MAX_BITS-1:0] core_outputx,
  input  logic [MAX_BITS-1:0] core_outputy,
  input  logic                core_finished,
  output logic [CNT_W-1:0]    last_latency
);

  arb_state_e r_state, w_state_next;

  logic                r_rr_ptr;
  logic                r_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_last_lat;
  logic [1:0]          r_mode;
  logic [MAX_BITS-1:0] r_a, r_prime, r_px, r_py, r_m;
  logic [MAX_BITS-1:0] r_rsp_x, r_rsp_y;

  logic                w_any_req;
  logic                w_grantee;
  logic                w_grant;
  logic                w_rsp_fire;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [MAX_BITS-1:0] w_mask;
  logic [MAX_BITS-1:0] w_sel_px, w_sel_py, w_sel_m;

  // Gate on rst so no ready is offered while reset is held.
  assign w_any_req = rst & (r0_req_valid | r1_req_valid);
  assign w_grantee = (r0_req_valid & r1_req_valid) ? r_rr_ptr : r1_req_valid;
  assign w_grant   = (r_state == StIdle) & w_any_req;
  assign w_rsp_fire = (r_state == StResp) & (r_owner ? r1_rsp_ready : r0_rsp_ready);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  assign w_sel_px = w_grantee ? r1_px : r0_px;
  assign w_sel_py = w_grantee ? r1_py : r0_py;
  assign w_sel_m  = w_grantee ? r1_m  : r0_m;

  ecc_width_mask #(
    .MaxBits(MAX_BITS)
  ) u_width_mask (
    .i_mode(cfg_mode),
    .o_mask(w_mask)
  );

  always_comb begin
    w_state_next = r_state;
    r0_req_ready = 1'b0;
    r1_req_ready = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    core_valid   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          r0_req_ready = ~w_grantee;
          r1_req_ready = w_grantee;
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        // Drop start in the finish cycle so the core never sees a re-trigger.
        core_valid = ~core_finished;
        if (core_finished) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        r0_rsp_valid = ~r_owner;
        r1_rsp_valid = r_owner;
        if (w_rsp_fire) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_rr_ptr   <= 1'b0;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_last_lat <= '0;
      r_mode     <= Bits32;
      r_a        <= '0;
      r_prime    <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_m        <= '0;
      r_rsp_x    <= '0;
      r_rsp_y    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_a      <= cfg_a & w_mask;
        r_prime  <= cfg_prime & w_mask;
        r_px     <= w_sel_px & w_mask;
        r_py     <= w_sel_py & w_mask;
        r_m      <= w_sel_m & w_mask;
        r_mode   <= cfg_mode;
        r_owner  <= w_grantee;
        r_rr_ptr <= ~w_grantee;
        r_cnt    <= '0;
      end
      if (r_state == StBusy) begin
        r_cnt <= w_cnt_inc;
        if (core_finished) begin
          r_rsp_x    <= core_outputx;
          r_rsp_y    <= core_outputy;
          r_last_lat <= w_cnt_inc;
        end
      end
    end
  end

  assign rsp_x        = r_rsp_x;
  assign rsp_y        = r_rsp_y;
  assign rsp_owner    = r_owner;
  assign core_a       = r_a;
  assign core_prime   = r_prime;
  assign core_pointx  = r_px;
  assign core_pointy  = r_py;
  assign core_mul     = r_m;
  assign core_mode    = r_mode;
  assign last_latency = r_last_lat;

endmodule

// File: doc/ecc_core_arbiter.md
Name: ecc_core_arbiter

Overview:
- Shares one scalar-multiplication core (double-and-add) between two independent requesters, e.g. the mP and mnP paths of the serial I/O front end.
- Arbitrates round-robin, latches the winner's operands and masks them to the selected width, and holds core_valid for the whole computation.
- Captures the result on core_finished and returns it through a per-requester valid/ready response with single-entry buffering.
- Also reports the core latency of the last operation.

Parameters:
- MAX_BITS, 128, datapath width; must equal the core's MAX_BITS.
- CNT_W, 16, width of the latency counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- r0_req_valid  in  1  requester 0 request
- r0_req_ready  out  1  requester 0 accepted
- r0_px, r0_py, r0_m  in  MAX_BITS each  requester 0 point x/y and scalar
- r1_req_valid, r1_req_ready, r1_px, r1_py, r1_m  same as requester 0, for requester 1
- cfg_a  in  MAX_BITS  curve coefficient a
- cfg_prime  in  MAX_BITS  field prime
- cfg_mode  in  2  width select (BITS16/32/64/128)
- r0_rsp_valid, r1_rsp_valid  out  1 each  result available for that requester
- r0_rsp_ready, r1_rsp_ready  in  1 each  requester takes the result
- rsp_x, rsp_y  out  MAX_BITS each  result, shared by both requesters
- rsp_owner  out  1  requester that owns the current result
- core_valid  out  1  core start/hold
- core_a, core_prime, core_pointx, core_pointy, core_mul  out  MAX_BITS each  operands (registered)
- core_mode  out  2  operand width select
- core_outputx, core_outputy  in  MAX_BITS each  core result
- core_finished  in  1  one-cycle done pulse from core
- last_latency  out  CNT_W  BUSY cycles of the last completed operation

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, all operand/result registers 0, every valid/ready output 0, core_mode=BITS32, last_latency=0. The core shares rst. Reset mid-operation abandons the operation and nothing is returned.
- States: IDLE, BUSY, RESP.
- IDLE, arbitration:
  - grant = the only valid requester; if both are valid, rr_ptr wins.
  - rx_req_ready=1 combinationally for the grantee only.
  - In the handshake cycle T: latch px/py/m of the grantee plus cfg_a/cfg_prime/cfg_mode.
  - Latched operands are masked: bits at or above the width selected by cfg_mode are forced to 0.
  - owner=grantee, rr_ptr=~grantee, latency counter cleared, state=BUSY at T+1.
- BUSY:
  - core_valid = 1 & ~core_finished, so it drops in the finish cycle itself.
  - Operands stay stable for the whole state.
  - Counter increments each BUSY cycle and saturates at all-ones.
  - On core_finished in cycle F: capture core_outputx/y into rsp_x/rsp_y, last_latency = counter+1, state=RESP at F+1.
- RESP:
  - r{owner}_rsp_valid=1; the other requester's rsp_valid=0.
  - rsp_x/rsp_y/rsp_owner are held stable until the handshake.
  - On rsp_valid&rsp_ready: next state is IDLE.
  - No new grant in RESP; a new grant is possible one cycle after the response handshake.
- Config inputs are sampled only at grant; changes during BUSY/RESP have no effect.
- core_finished outside BUSY is ignored.
- req_valid dropping before it is granted is legal; nothing is latched.
- rsp_ready while rsp_valid=0 is ignored.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1.

Decomposition:
- Shared package/header (existing ECC define header): BITS16/32/64/128 encodings, MAX_BITS, state encodings.
- Sub-module ecc_width_mask (combinational mode -> MAX_BITS mask), instantiated once and applied to all five latched operands.
- Round-robin pointer and FSM stay in the top.

Test Plan:
- Single request: r0_req_valid with px=0x1234, py=0x5678, m=7, mode=BITS16. Required: ready in the same cycle, core_valid from the next cycle. Core model finishes after 40 cycles with out=(0xAAAA, 0x5555). Required: r0_rsp_valid=1, rsp_x=0xAAAA, rsp_y=0x5555, rsp_owner=0, last_latency=40.
- Masking: mode=BITS16, r1_px=0x1_ABCD, cfg_prime=0xF_FFF1. Required: core_pointx=0xABCD, core_prime=0xFFF1.
- Contention: both requesters valid from reset, core latency 10. Required grant order 0,1,0,1 over 4 ops, each response routed to the correct rsp_valid.
- Response backpressure: hold r0_rsp_ready=0 for 20 cycles while r1 requests. Required: r1_req_ready stays 0, rsp_x stable, core_valid=0. Release: r1 granted the cycle after the handshake.
- Config change in BUSY: change cfg_mode and cfg_a mid-operation. Required: core_mode and core_a unchanged until the next grant.
- Async reset mid-BUSY: assert rst with no clock edge. Required: core_valid=0, all rsp_valid=0, last_latency=0 immediately. After release, a fresh r1 request is granted (rr_ptr=0, r0 idle).
